instr_reg_reader: RTL and testbench



---
 rtl/instr_reg_reader.sv | 196 +++++++++++++++++++
 tb/tb_instr_reg_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_reader.sv
// Read-side companion of the instruction register: walks a window of entries,
// recomputes each result from opcode/operands and streams word + verdict out.
module instr_reg_reader #(
  parameter int OPERAND_W = 32,
  parameter int RESULT_W  = 64,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    first_addr,
  input  logic [ADDR_W:0]      num_words,
  output logic [ADDR_W-1:0]    read_pointer,
  input  logic [3:0]           iw_opcode,
  input  logic [OPERAND_W-1:0] iw_op_a,
  input  logic [OPERAND_W-1:0] iw_op_b,
  input  logic [RESULT_W-1:0]  iw_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_index,
  output logic [3:0]           out_opcode,
  output logic [OPERAND_W-1:0] out_op_a,
  output logic [OPERAND_W-1:0] out_op_b,
  output logic [RESULT_W-1:0]  out_result,
  output logic [RESULT_W-1:0]  out_expected,
  output logic                 out_mismatch,
  output logic                 out_div0,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      error_count,
  output logic [ADDR_W:0]      checked_count
);

  typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     ptr_reg, ptr_next;
  logic [ADDR_W:0]       remaining_reg, remaining_next;
  logic [ADDR_W:0]       err_reg, err_next;
  logic [ADDR_W:0]       chk_reg, chk_next;
  logic                  valid_reg, valid_next;
  logic [ADDR_W-1:0]     index_reg, index_next;
  logic [3:0]            opcode_reg, opcode_next;
  logic [OPERAND_W-1:0]  op_a_reg, op_a_next;
  logic [OPERAND_W-1:0]  op_b_reg, op_b_next;
  logic [RESULT_W-1:0]   result_reg, result_next;
  logic [RESULT_W-1:0]   expected_reg, expected_next;
  logic                  mismatch_reg, mismatch_next;
  logic                  div0_reg, div0_next;

  logic signed [RESULT_W-1:0] a_ext, b_ext, calc;
  logic                       calc_div0;

  // Reference result for the entry currently addressed by read_pointer.
  always_comb begin
    a_ext     = {{(RESULT_W-OPERAND_W){iw_op_a[OPERAND_W-1]}}, iw_op_a};
    b_ext     = {{(RESULT_W-OPERAND_W){iw_op_b[OPERAND_W-1]}}, iw_op_b};
    calc      = '0;
    calc_div0 = 1'b0;
    case (iw_opcode)
      OP_PASSA: calc = a_ext;
      OP_PASSB: calc = b_ext;
      OP_ADD:   calc = a_ext + b_ext;
      OP_SUB:   calc = a_ext - b_ext;
      OP_MULT:  calc = a_ext * b_ext;
      OP_DIV: begin
        if (b_ext == '0) calc_div0 = 1'b1;
        else             calc = a_ext / b_ext;
      end
      OP_MOD: begin
        if (b_ext == '0) calc_div0 = 1'b1;
        else             calc = a_ext % b_ext;
      end
      default:  calc = '0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    err_next       = err_reg;
    chk_next       = chk_reg;
    valid_next     = valid_reg;
    index_next     = index_reg;
    opcode_next    = opcode_reg;
    op_a_next      = op_a_reg;
    op_b_next      = op_b_reg;
    result_next    = result_reg;
    expected_next  = expected_reg;
    mismatch_next  = mismatch_reg;
    div0_next      = div0_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          err_next = '0;
          chk_next = '0;
          if (num_words != '0) begin
            ptr_next       = first_addr;
            remaining_next = num_words;
            state_next     = READ;
          end else begin
            state_next = DONE;
          end
        end
      end
      READ: begin
        index_next    = ptr_reg;
        opcode_next   = iw_opcode;
        op_a_next     = iw_op_a;
        op_b_next     = iw_op_b;
        result_next   = iw_result;
        expected_next = calc;
        div0_next     = calc_div0;
        mismatch_next = !calc_div0 && (iw_result != calc);
        valid_next    = 1'b1;
        state_next    = OUT;
      end
      OUT: begin
        if (valid_reg && out_ready) begin
          valid_next = 1'b0;
          chk_next   = chk_reg + (ADDR_W+1)'(1);
          if (mismatch_reg) err_next = err_reg + (ADDR_W+1)'(1);
          if (remaining_reg == (ADDR_W+1)'(1)) begin
            state_next = DONE;
          end else begin
            // Natural ADDR_W-bit overflow gives the wrap to entry 0.
            ptr_next       = ptr_reg + ADDR_W'(1);
            remaining_next = remaining_reg - (ADDR_W+1)'(1);
            state_next     = READ;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      err_reg       <= '0;
      chk_reg       <= '0;
      valid_reg     <= 1'b0;
      index_reg     <= '0;
      opcode_reg    <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      result_reg    <= '0;
      expected_reg  <= '0;
      mismatch_reg  <= 1'b0;
      div0_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      err_reg       <= err_next;
      chk_reg       <= chk_next;
      valid_reg     <= valid_next;
      index_reg     <= index_next;
      opcode_reg    <= opcode_next;
      op_a_reg      <= op_a_next;
      op_b_reg      <= op_b_next;
      result_reg    <= result_next;
      expected_reg  <= expected_next;
      mismatch_reg  <= mismatch_next;
      div0_reg      <= div0_next;
    end
  end

  assign read_pointer  = ptr_reg;
  assign out_valid     = valid_reg;
  assign out_index     = index_reg;
  assign out_opcode    = opcode_reg;
  assign out_op_a      = op_a_reg;
  assign out_op_b      = op_b_reg;
  assign out_result    = result_reg;
  assign out_expected  = expected_reg;
  assign out_mismatch  = mismatch_reg;
  assign out_div0      = div0_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign error_count   = err_reg;
  assign checked_count = chk_reg;

endmodule

// File: tb/tb_instr_reg_reader.sv
// Bench for instr_reg_reader: table vectors, directed corner sequences and
// randomized runs against a simple arithmetic reference model.
module tb_instr_reg_reader;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [4:0]  first_addr, read_pointer, out_index;
  logic [5:0]  num_words, error_count, checked_count;
  logic [3:0]  iw_opcode, out_opcode;
  logic [31:0] iw_op_a, iw_op_b, out_op_a, out_op_b;
  logic [63:0] iw_result, out_result, out_expected;
  logic        out_valid, out_mismatch, out_div0, busy, done;

  logic [3:0] m_op [32];
  int         m_a  [32];
  int         m_b  [32];
  longint     m_r  [32];

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  assign iw_opcode = m_op[read_pointer];
  assign iw_op_a   = m_a[read_pointer];
  assign iw_op_b   = m_b[read_pointer];
  assign iw_result = m_r[read_pointer];

  instr_reg_reader dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
    .num_words(num_words), .read_pointer(read_pointer), .iw_opcode(iw_opcode),
    .iw_op_a(iw_op_a), .iw_op_b(iw_op_b), .iw_result(iw_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_opcode(out_opcode), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_result(out_result), .out_expected(out_expected),
    .out_mismatch(out_mismatch), .out_div0(out_div0), .busy(busy), .done(done),
    .error_count(error_count), .checked_count(checked_count)
  );

  always @(posedge clk) if (done) done_seen++;

  typedef struct {
    logic [3:0] op;
    int         a;
    int         b;
    longint     res;
    longint     exp;
    bit         mm;
    bit         dz;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, $signed(got), $signed(exp));
    end
  endtask

  // Reference arithmetic straight from the opcode definitions.
  function automatic longint model(input logic [3:0] op, input int a, input int b, output bit dz);
    longint la = a;
    longint lb = b;
    dz = 1'b0;
    case (op)
      4'd1: return la;
      4'd2: return lb;
      4'd3: return la + lb;
      4'd4: return la - lb;
      4'd5: return la * lb;
      4'd6: begin if (lb == 0) begin dz = 1'b1; return 0; end return la / lb; end
      4'd7: begin if (lb == 0) begin dz = 1'b1; return 0; end return la % lb; end
      default: return 0;
    endcase
  endfunction

  task automatic wait_valid(output bit ok);
    int guard = 0;
    while (!out_valid && guard < 10) begin @(negedge clk); guard++; end
    ok = out_valid;
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_done(output bit ok);
    int guard = 0;
    while (!done && guard < 5) begin @(negedge clk); guard++; end
    ok = done;
    chk("done_seen", done, 1);
  endtask

  // Full run checked against the model; stall<0 means a fixed -stall cycle hold.
  task automatic run_model(input int first, input int n, input int stall);
    int idx, errs, hold;
    bit dz, mm, ok, stable;
    longint e;
    logic [63:0] snap_res, snap_exp;
    logic [4:0]  snap_idx, snap_ptr;
    errs = 0;
    start = 1; first_addr = 5'(first); num_words = 6'(n);
    @(negedge clk);
    start = 0;
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", out_valid, 0);
    end
    for (int k = 0; k < n; k++) begin
      wait_valid(ok);
      if (!ok) return;
      idx = (first + k) % 32;
      e   = model(m_op[idx], m_a[idx], m_b[idx], dz);
      mm  = !dz && (m_r[idx] != e);
      errs += int'(mm);
      chk("out_index", out_index, idx);
      chk("read_pointer", read_pointer, idx);
      chk("out_result", out_result, m_r[idx]);
      chk("out_expected", out_expected, e);
      chk("out_div0", out_div0, dz);
      chk("out_mismatch", out_mismatch, mm);
      $display("[TB] word idx=%0d op=%0d exp=%0d mm=%0d dz=%0d", idx, m_op[idx], e, mm, dz);
      hold = (stall < 0) ? -stall : ((stall > 0) ? int'($urandom_range(0, stall)) : 0);
      snap_res = out_result; snap_exp = out_expected; snap_idx = out_index; snap_ptr = read_pointer;
      stable = 1;
      for (int s = 0; s < hold; s++) begin
        @(negedge clk);
        if (!out_valid || out_result !== snap_res || out_expected !== snap_exp ||
            out_index !== snap_idx || read_pointer !== snap_ptr || checked_count !== 6'(k))
          stable = 0;
      end
      if (hold > 0) chk("hold_stable", stable, 1);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("checked_step", checked_count, k + 1);
    end
    if (n > 0) wait_done(ok);
    chk("checked_count", checked_count, n);
    chk("error_count", error_count, errs);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
    $display("[TB] run first=%0d n=%0d errors=%0d", first, n, errs);
  endtask

  task automatic load(input int i, input logic [3:0] op, input int a, input int b, input longint r);
    m_op[i] = op; m_a[i] = a; m_b[i] = b; m_r[i] = r;
  endtask

  initial begin
    bit ok, dz;
    int addr, d0;
    longint e;

    tbl[0]  = '{4'd3, 5, -7, -2, -2, 0, 0};
    tbl[1]  = '{4'd5, -3, 4, -12, -12, 0, 0};
    tbl[2]  = '{4'd4, 10, 3, 99, 7, 1, 0};
    tbl[3]  = '{4'd6, 8, 0, 123, 0, 0, 1};
    tbl[4]  = '{4'd7, -7, 2, -1, -1, 0, 0};
    tbl[5]  = '{4'd6, -7, 2, -3, -3, 0, 0};
    tbl[6]  = '{4'd7, 7, -2, 1, 1, 0, 0};
    tbl[7]  = '{4'd1, -9, 4, -9, -9, 0, 0};
    tbl[8]  = '{4'd2, -9, 4, 5, 4, 1, 0};
    tbl[9]  = '{4'd9, 3, 4, 0, 0, 0, 0};
    tbl[10] = '{4'd5, 32'sh80000000, 32'sh80000000, 64'sh4000000000000000, 64'sh4000000000000000, 0, 0};
    tbl[11] = '{4'd0, 1, 1, 1, 0, 1, 0};

    for (int i = 0; i < 32; i++) load(i, 4'd0, 0, 0, 0);
    reset = 1; start = 0; out_ready = 0; first_addr = 0; num_words = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ptr", read_pointer, 0);
    chk("rst_expected", out_expected, 0);
    chk("rst_checked", checked_count, 0);
    chk("rst_errors", error_count, 0);

    // Table: one single-word run per vector.
    for (int i = 0; i < 12; i++) begin
      addr = (i * 7 + 3) % 32;
      load(addr, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res);
      start = 1; first_addr = 5'(addr); num_words = 6'd1;
      @(negedge clk);
      start = 0;
      wait_valid(ok);
      if (ok) begin
        chk("tbl_expected", out_expected, tbl[i].exp);
        chk("tbl_mismatch", out_mismatch, tbl[i].mm);
        chk("tbl_div0", out_div0, tbl[i].dz);
        $display("[TB] vec %0d op=%0d exp=%0d mm=%0d", i, tbl[i].op, tbl[i].exp, tbl[i].mm);
        out_ready = 1; @(negedge clk); out_ready = 0;
        wait_done(ok);
        chk("tbl_errors", error_count, tbl[i].mm);
      end
      @(negedge clk);
    end

    // Two-word run, then wrap-around, long stall, and empty run.
    load(3, 4'd3, 5, -7, -2);
    load(4, 4'd5, -3, 4, -12);
    out_ready = 0;
    run_model(3, 2, 0);
    load(31, 4'd4, 100, 1, 99);
    load(0, 4'd6, -20, 3, -6);
    load(1, 4'd7, -20, 3, 5);
    run_model(31, 3, 1);
    load(8, 4'd3, 1, 2, 3);
    run_model(8, 1, -5);
    d0 = done_seen;
    run_model(0, 0, 0);
    chk("zero_done_once", done_seen - d0, 1);

    // Reset while a word is waiting in OUT aborts without a done pulse.
    load(12, 4'd1, 1, 0, 1); load(13, 4'd1, 2, 0, 9); load(14, 4'd1, 3, 0, 3);
    start = 1; first_addr = 5'd12; num_words = 6'd3;
    @(negedge clk); start = 0;
    wait_valid(ok);
    out_ready = 1; @(negedge clk); out_ready = 0;
    wait_valid(ok);
    d0 = done_seen;
    reset = 1; @(negedge clk); reset = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_checked", checked_count, 0);
    chk("abort_ptr", read_pointer, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    $display("[TB] reset abort checked");

    // start while busy is ignored.
    load(5, 4'd3, 1, 1, 2); load(6, 4'd3, 2, 2, 4); load(20, 4'd3, 9, 9, 0);
    start = 1; first_addr = 5'd5; num_words = 6'd2;
    @(negedge clk);
    first_addr = 5'd20; num_words = 6'd1;
    @(negedge clk); start = 0;
    wait_valid(ok);
    chk("busy_start_idx0", out_index, 5);
    out_ready = 1; @(negedge clk); out_ready = 0;
    wait_valid(ok);
    chk("busy_start_idx1", out_index, 6);
    out_ready = 1; @(negedge clk); out_ready = 0;
    wait_done(ok);
    chk("busy_start_checked", checked_count, 2);
    @(negedge clk);
    $display("[TB] start-while-busy checked");

    // Randomized runs with occasional corrupted stored results.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) begin
        m_op[i] = 4'($urandom_range(0, 15));
        m_a[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom);
        m_b[i]  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
        e = model(m_op[i], m_a[i], m_b[i], dz);
        m_r[i]  = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)} : e;
      end
      run_model(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)), 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
